// File: rtl/forwarding_hazard_ctrl_if.sv
// forwarding_hazard_ctrl_if: ID/EX/MEM hazard inputs plus forwarding selects and status back to the pipeline.
interface forwarding_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic                  forwarding_en;
    logic                  flush;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_two_src;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_wb_en;
    logic                  ex_mem_r_en;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  mem_wb_en;
    logic                  hazard_stall;
    logic [1:0]            sel_src1;
    logic [1:0]            sel_src2;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      fwd_cnt;
    logic                  hazard_err;

    modport master (
        output forwarding_en, flush, id_valid, id_src1, id_src2, id_two_src,
               ex_dest, ex_wb_en, ex_mem_r_en, mem_dest, mem_wb_en,
        input  hazard_stall, sel_src1, sel_src2, stall_cnt, fwd_cnt, hazard_err
    );
    modport slave (
        input  forwarding_en, flush, id_valid, id_src1, id_src2, id_two_src,
               ex_dest, ex_wb_en, ex_mem_r_en, mem_dest, mem_wb_en,
        output hazard_stall, sel_src1, sel_src2, stall_cnt, fwd_cnt, hazard_err
    );
endinterface

// File: rtl/forwarding_hazard_ctrl.sv
// forwarding_hazard_ctrl: load-use / stall-only hazard detection, registered EX forwarding selects,
// saturating stall/forward counters and a sticky stall-overrun flag.
module forwarding_hazard_ctrl #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16,
    parameter int MAX_STALL  = 2
) (
    input logic                     clk,
    input logic                     rst,
    forwarding_hazard_ctrl_if.slave bus
);
    localparam logic [1:0] SEL_ID  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;
    localparam int         SCNT_W  = $clog2(MAX_STALL + 1);

    typedef enum logic {RUN, STALL} state_t;

    state_t                state_q, state_d;
    logic [SCNT_W-1:0]     scnt_q, scnt_d;
    logic [1:0]            sel1_q, sel1_d, sel2_q, sel2_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;
    logic                  err_q, err_d, err_set;
    logic [REG_ADDR_W-1:0] src1, src2;
    logic                  use1, use2, m_ex1, m_ex2, m_mem1, m_mem2, stall, bubble;
    logic [1:0]            fwd_inc;
    logic [CNT_W:0]        fwd_sum, stall_sum;

    always_comb begin
        src1   = bus.id_src1;
        src2   = bus.id_src2;
        use1   = bus.id_valid;
        use2   = bus.id_valid & bus.id_two_src;
        m_ex1  = use1 & bus.ex_wb_en & (src1 == bus.ex_dest);
        m_ex2  = use2 & bus.ex_wb_en & (src2 == bus.ex_dest);
        m_mem1 = use1 & bus.mem_wb_en & (src1 == bus.mem_dest);
        m_mem2 = use2 & bus.mem_wb_en & (src2 == bus.mem_dest);
        stall  = ~bus.flush & (bus.forwarding_en ? bus.ex_mem_r_en & (m_ex1 | m_ex2)
                                                 : (m_ex1 | m_ex2 | m_mem1 | m_mem2));
        bubble = bus.flush | stall | ~bus.forwarding_en;
        // youngest producer wins: an EX hit is in MEM by the time this instruction reaches EX
        sel1_d = bubble ? SEL_ID : m_ex1 ? SEL_MEM : m_mem1 ? SEL_WB : SEL_ID;
        sel2_d = bubble ? SEL_ID : m_ex2 ? SEL_MEM : m_mem2 ? SEL_WB : SEL_ID;
    end

    always_comb begin
        fwd_inc     = {1'b0, sel1_d != SEL_ID} + {1'b0, sel2_d != SEL_ID};
        fwd_sum     = {1'b0, fwd_cnt_q} + (CNT_W+1)'(fwd_inc);
        stall_sum   = {1'b0, stall_cnt_q} + (CNT_W+1)'(stall);
        fwd_cnt_d   = fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
        stall_cnt_d = stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            scnt_q      <= '0;
            sel1_q      <= SEL_ID;
            sel2_q      <= SEL_ID;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            sel1_q      <= sel1_d;
            sel2_q      <= sel2_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = bus.flush ? RUN : stall ? STALL : RUN;
        scnt_d  = (bus.flush | ~stall) ? '0
                : (state_q == RUN) ? SCNT_W'(1)
                : (scnt_q == SCNT_W'(MAX_STALL)) ? scnt_q : scnt_q + SCNT_W'(1);
    end

    always_comb begin
        err_set = (state_q == STALL) & stall & (scnt_q >= SCNT_W'(MAX_STALL));
        err_d   = err_q | err_set;
    end

    assign bus.hazard_stall = stall;
    assign bus.sel_src1     = sel1_q;
    assign bus.sel_src2     = sel2_q;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.fwd_cnt      = fwd_cnt_q;
    assign bus.hazard_err   = err_q;
endmodule

// File: tb/tb_forwarding_hazard_ctrl.sv
// tb_forwarding_hazard_ctrl: directed and random stimulus against a behavioural model; a CNT_W=4 twin checks saturation.
module tb_forwarding_hazard_ctrl;
    localparam int MAX_STALL = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    forwarding_hazard_ctrl_if #(.REG_ADDR_W(4), .CNT_W(16)) a ();
    forwarding_hazard_ctrl_if #(.REG_ADDR_W(4), .CNT_W(4))  b ();

    forwarding_hazard_ctrl #(.REG_ADDR_W(4), .CNT_W(16), .MAX_STALL(MAX_STALL)) u_dut (.clk(clk), .rst(rst), .bus(a.slave));
    forwarding_hazard_ctrl #(.REG_ADDR_W(4), .CNT_W(4),  .MAX_STALL(MAX_STALL)) u_sat (.clk(clk), .rst(rst), .bus(b.slave));

    int checks = 0;
    int errors = 0;

    int  m_sel1, m_sel2, m_scnt, m_fcnt, m_run;
    bit  m_err;
    bit  mvalid = 0;

    bit r, fe, fl, v, two, ewb, eld, mwb;
    int s1, s2, ed, md;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int x, input int w);
        return (x > (1 << w) - 1) ? (1 << w) - 1 : x;
    endfunction

    task automatic step();
        bit u1, u2, x1, x2, y1, y2, st;
        int n1, n2;
        @(negedge clk);
        if (mvalid) begin
            check("sel_src1", int'(a.sel_src1), m_sel1);
            check("sel_src2", int'(a.sel_src2), m_sel2);
            check("stall_cnt", int'(a.stall_cnt), sat(m_scnt, 16));
            check("fwd_cnt", int'(a.fwd_cnt), sat(m_fcnt, 16));
            check("hazard_err", int'(a.hazard_err), int'(m_err));
            check("sat_stall_cnt", int'(b.stall_cnt), sat(m_scnt, 4));
            check("sat_fwd_cnt", int'(b.fwd_cnt), sat(m_fcnt, 4));
        end
        rst = r;
        a.forwarding_en = fe;  b.forwarding_en = fe;
        a.flush = fl;          b.flush = fl;
        a.id_valid = v;        b.id_valid = v;
        a.id_src1 = 4'(s1);    b.id_src1 = 4'(s1);
        a.id_src2 = 4'(s2);    b.id_src2 = 4'(s2);
        a.id_two_src = two;    b.id_two_src = two;
        a.ex_dest = 4'(ed);    b.ex_dest = 4'(ed);
        a.ex_wb_en = ewb;      b.ex_wb_en = ewb;
        a.ex_mem_r_en = eld;   b.ex_mem_r_en = eld;
        a.mem_dest = 4'(md);   b.mem_dest = 4'(md);
        a.mem_wb_en = mwb;     b.mem_wb_en = mwb;
        #1;
        u1 = v;
        u2 = v && two;
        x1 = u1 && ewb && s1 == ed;
        x2 = u2 && ewb && s2 == ed;
        y1 = u1 && mwb && s1 == md;
        y2 = u2 && mwb && s2 == md;
        if (fl) st = 0;
        else if (fe) st = eld && (x1 || x2);
        else st = x1 || x2 || y1 || y2;
        check("hazard_stall", int'(a.hazard_stall), int'(st));
        check("sat_hazard_stall", int'(b.hazard_stall), int'(st));
        if (r) begin
            m_sel1 = 0; m_sel2 = 0; m_scnt = 0; m_fcnt = 0; m_err = 0; m_run = 0;
            mvalid = 1;
        end else begin
            if (fl || st || !fe) begin
                n1 = 0; n2 = 0;
            end else begin
                n1 = x1 ? 1 : y1 ? 2 : 0;
                n2 = x2 ? 1 : y2 ? 2 : 0;
            end
            m_sel1 = n1;
            m_sel2 = n2;
            m_fcnt += (n1 != 0) + (n2 != 0);
            m_scnt += st;
            if (fl || !st) m_run = 0;
            else begin
                m_run++;
                if (m_run > MAX_STALL) m_err = 1;
            end
        end
    endtask

    task automatic stim(input bit ir, ife, ifl, iv, input int is1, is2, input bit itwo,
                        input int ied, input bit iewb, ield, input int imd, input bit imwb);
        r = ir; fe = ife; fl = ifl; v = iv; s1 = is1; s2 = is2; two = itwo;
        ed = ied; ewb = iewb; eld = ield; md = imd; mwb = imwb;
        step();
    endtask

    function automatic int pick_reg();
        int p = $urandom_range(0, 4);
        return p == 4 ? 15 : p;
    endfunction

    initial begin
        // no hazard
        stim(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        stim(0, 1, 0, 1, 1, 2, 1, 3, 1, 0, 0, 0);
        check("nohaz_stall", int'(a.hazard_stall), 0);
        stim(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("nohaz_sel1", int'(a.sel_src1), 0);
        check("nohaz_fwd_cnt", int'(a.fwd_cnt), 0);
        // ALU->ALU forwarding, EX beats MEM
        stim(0, 1, 0, 1, 2, 0, 0, 2, 1, 0, 2, 1);
        check("alu_stall", int'(a.hazard_stall), 0);
        stim(0, 1, 0, 1, 5, 0, 0, 0, 0, 0, 5, 1);
        check("alu_sel1_ex", int'(a.sel_src1), 1);
        check("alu_fwd_cnt1", int'(a.fwd_cnt), 1);
        stim(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("alu_sel1_mem", int'(a.sel_src1), 2);
        check("alu_fwd_cnt2", int'(a.fwd_cnt), 2);
        // load-use
        stim(0, 1, 0, 1, 9, 4, 1, 4, 1, 1, 0, 0);
        check("lu_stall", int'(a.hazard_stall), 1);
        stim(0, 1, 0, 1, 9, 4, 1, 0, 0, 0, 4, 1);
        check("lu_stall_done", int'(a.hazard_stall), 0);
        check("lu_sel2_bubble", int'(a.sel_src2), 0);
        stim(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("lu_sel2_wb", int'(a.sel_src2), 2);
        check("lu_stall_cnt", int'(a.stall_cnt), 1);
        check("lu_err", int'(a.hazard_err), 0);
        // stall-only mode, producer walks EX -> MEM -> gone
        stim(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        stim(0, 0, 0, 1, 7, 0, 0, 7, 1, 0, 0, 0);
        check("so_stall1", int'(a.hazard_stall), 1);
        stim(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 7, 1);
        check("so_stall2", int'(a.hazard_stall), 1);
        stim(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        check("so_stall3", int'(a.hazard_stall), 0);
        check("so_stall_cnt", int'(a.stall_cnt), 2);
        check("so_err", int'(a.hazard_err), 0);
        // overrun, flush mid-stall, reset
        stim(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) stim(0, 1, 0, 1, 4, 0, 0, 4, 1, 1, 0, 0);
        stim(0, 1, 1, 1, 4, 0, 0, 4, 1, 1, 0, 0);
        check("ov_flush_stall", int'(a.hazard_stall), 0);
        check("ov_err", int'(a.hazard_err), 1);
        stim(0, 1, 0, 1, 4, 0, 0, 4, 1, 1, 0, 0);
        check("ov_after_flush_stall", int'(a.hazard_stall), 1);
        check("ov_err_sticky", int'(a.hazard_err), 1);
        check("ov_flush_sel1", int'(a.sel_src1), 0);
        stim(1, 1, 0, 1, 4, 0, 0, 4, 1, 1, 0, 0);
        stim(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_err", int'(a.hazard_err), 0);
        check("rst_stall_cnt", int'(a.stall_cnt), 0);
        // saturation
        for (int i = 0; i < 20; i++) stim(0, 0, 0, 1, 6, 0, 0, 6, 1, 0, 0, 0);
        stim(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("sat4_stall_cnt", int'(b.stall_cnt), 15);
        check("sat16_stall_cnt", int'(a.stall_cnt), 20);
        // random
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                fe = $urandom_range(0, 3) != 0;
                v = $urandom_range(0, 7) != 0;
                s1 = pick_reg(); s2 = pick_reg(); two = $urandom_range(0, 1);
                ed = pick_reg(); ewb = $urandom_range(0, 3) != 0; eld = $urandom_range(0, 1);
                md = pick_reg(); mwb = $urandom_range(0, 3) != 0;
            end
            r = $urandom_range(0, 59) == 0;
            fl = $urandom_range(0, 11) == 0;
            step();
        end
        r = 0; fl = 0; v = 0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/forwarding_hazard_ctrl.md
Name: forwarding_hazard_ctrl

Overview:
Sequencing controller for the EX-stage operand forwarding muxes (3-to-1 select: ID / MEM / WB) of the 5-stage ARM pipeline.
- Evaluates the instruction in ID against destinations in EX and MEM.
- Raises a stall on unresolvable hazards.
- Registers the per-operand forwarding selects so they are valid while that instruction is in EX.
- Also keeps stall/forward performance counters and a sticky stall-overrun error flag.

Parameters:
REG_ADDR_W, 4, register-file address width
CNT_W, 16, width of performance counters (saturating)
MAX_STALL, 2, max legal consecutive stall cycles before hazard_err sets

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  synchronous reset, active-high
forwarding_en  input  1  1 = forwarding mode, 0 = stall-only mode
flush  input  1  branch taken; kills ID/EX contents
id_valid  input  1  ID holds a real instruction
id_src1  input  REG_ADDR_W  ID source register Rn
id_src2  input  REG_ADDR_W  ID source register Rm/Rd
id_two_src  input  1  id_src2 is actually read
ex_dest  input  REG_ADDR_W  destination of instruction in EX
ex_wb_en  input  1  EX instruction writes back
ex_mem_r_en  input  1  EX instruction is a load
mem_dest  input  REG_ADDR_W  destination of instruction in MEM
mem_wb_en  input  1  MEM instruction writes back
hazard_stall  output  1  combinational: freeze PC/IF-ID, bubble into ID/EX
sel_src1  output  2  registered forwarding select, EX operand 1
sel_src2  output  2  registered forwarding select, EX operand 2
stall_cnt  output  CNT_W  count of stall cycles
fwd_cnt  output  CNT_W  count of operands forwarded
hazard_err  output  1  sticky: stall exceeded MAX_STALL cycles

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Select encoding, using the shared forwarding-select defines: ID = 2'b00, MEM = 2'b01, WB = 2'b10. 2'b11 is never driven.
- Reset values:
  - sel_src1 = sel_src2 = 2'b00.
  - stall_cnt = fwd_cnt = 0.
  - hazard_err = 0.
  - FSM = RUN.
  - hazard_stall depends only on its inputs.
- Match definitions:
  - use1 = id_valid.
  - use2 = id_valid & id_two_src.
  - mEXk = use_k & ex_wb_en & (src_k == ex_dest).
  - mMEMk = use_k & mem_wb_en & (src_k == mem_dest).
- hazard_stall (combinational, zero latency):
  - forwarding_en = 1: hazard_stall = ex_mem_r_en & (mEX1 | mEX2). This is load-use only.
  - forwarding_en = 0: hazard_stall = mEX1 | mEX2 | mMEM1 | mMEM2.
  - flush = 1 forces hazard_stall = 0.
- Select register update, at each posedge, in priority order:
  - rst, flush or hazard_stall: both selects <= ID (bubble).
  - forwarding_en = 0: both <= ID.
  - Otherwise, per operand:
    - mEXk -> MEM, because that producer will be in MEM next cycle. EX beats MEM, since the youngest producer wins.
    - else mMEMk -> WB.
    - else ID.
  - An unused operand (use_k = 0) always gets ID.
- fwd_cnt:
  - += number of selects loaded with a non-ID value that cycle (0, 1 or 2).
  - Saturates at all-ones.
- stall_cnt:
  - += 1 every cycle hazard_stall = 1.
  - Saturates at all-ones.
- FSM, states RUN / STALL, with internal run counter scnt:
  - RUN -> STALL when hazard_stall = 1; scnt <= 1.
  - STALL, hazard_stall = 1: scnt += 1. If scnt reaches MAX_STALL and stalls again, hazard_err <= 1.
  - STALL, hazard_stall = 0: -> RUN, scnt <= 0.
  - flush in any state -> RUN, scnt <= 0. Counters and hazard_err are unaffected.
- hazard_err:
  - Sticky until rst.
  - Legal maxima: 1 stall cycle with forwarding, 2 without.
- Reset mid-stall: state RUN and selects ID on the next edge; counters cleared.
- Same register in EX and MEM: EX wins, giving MEM. A load in EX never reaches the select register because it stalls first.
- Register 15 gets no special treatment.

Test Plan:
- No hazard: reset, then EX dest R3 wb, ID src1 = R1, src2 = R2 two_src -> hazard_stall 0; next edge sel_src1 = sel_src2 = 00; fwd_cnt 0.
- ALU->ALU forwarding: fwd_en 1, EX dest R2 wb (not load), MEM dest R2 wb, ID src1 = R2 -> no stall; sel_src1 = 01 (EX wins); src1 = R5 with MEM dest R5 -> sel_src1 = 10; fwd_cnt increments by 1 each.
- Load-use: fwd_en 1, EX load dest R4, ID src2 = R4 two_src -> hazard_stall 1 for exactly 1 cycle, sels 00. Next cycle (load in MEM, dest R4): no stall, sel_src2 = 10; stall_cnt = 1; hazard_err 0.
- Stall-only mode: fwd_en 0, EX dest R7 wb, ID src1 = R7 -> stall 2 cycles as producer moves EX -> MEM -> out; selects always 00; stall_cnt = 2; hazard_err 0.
- Overrun and flush:
  - Hold a matching EX load for 3 cycles -> hazard_err = 1 after the 3rd stall cycle and stays set.
  - Assert flush mid-stall -> hazard_stall 0 that cycle, sels 00, FSM RUN.
  - rst -> all outputs back to reset values.
- Saturation: preload through CNT_W = 4 override, 20 consecutive stall cycles -> stall_cnt holds 15.
